// File: rtl/para.sv
// Shared flit-format constants, flit-type helpers and arbiter FSM state
// for the wormhole router.
package para;

    localparam int FLIT_SIZE  = 32;
    localparam int HEADER_LEN = 2;
    localparam int CMP_LEN    = 4;

    localparam logic [HEADER_LEN-1:0] HEAD_FLIT   = 2'd0;
    localparam logic [HEADER_LEN-1:0] BODY_FLIT   = 2'd1;
    localparam logic [HEADER_LEN-1:0] TAIL_FLIT   = 2'd2;
    localparam logic [HEADER_LEN-1:0] SINGLE_FLIT = 2'd3;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    function automatic logic opens_packet(input logic [HEADER_LEN-1:0] t);
        return (t == HEAD_FLIT) || (t == SINGLE_FLIT);
    endfunction

    function automatic logic closes_packet(input logic [HEADER_LEN-1:0] t);
        return (t == TAIL_FLIT) || (t == SINGLE_FLIT);
    endfunction

endpackage

// File: rtl/arb_age_counter.sv
// Saturating starvation counter for one requester: counts lost arbitration
// rounds up to AGE_MAX and clears when the requester is granted.
module arb_age_counter #(
    parameter int AGE_MAX = 15,
    parameter int AGE_W   = $clog2(AGE_MAX + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic saturated
);

    logic [AGE_W-1:0] count;

    assign saturated = (count == AGE_W'(AGE_MAX));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc && !saturated) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/wormhole_output_arbiter.sv
// Wormhole output-port arbiter: priority + round-robin selection of packet heads,
// locked to the owner until its tail. Define ARB_AGING_EN for starvation aging.
module wormhole_output_arbiter
    import para::*;
#(
    parameter int N       = 3,
    parameter int AGE_MAX = 15,
    localparam int IDX_W  = (N > 1) ? $clog2(N) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N-1:0]             req_valid,
    input  logic [HEADER_LEN*N-1:0]  req_type,
    input  logic [CMP_LEN*N-1:0]     req_prio,
    input  logic                     out_avail,
    output logic [N-1:0]             grant,
    output logic [IDX_W-1:0]         grant_idx,
    output logic [N-1:0]             consume,
    output logic                     out_valid,
    output logic                     busy
);

    localparam int SUM_W = IDX_W + 1;

    arb_state_t       state;
    logic [IDX_W-1:0] rr_ptr;
    logic [N-1:0]     eligible;
    logic [N-1:0]     closing;
    logic [N-1:0]     aged;
    logic [CMP_LEN:0] key [N];
    logic             found;
    logic [IDX_W-1:0] best_idx;
    logic [IDX_W-1:0] cand;
    logic [CMP_LEN:0] best_key;
    logic [SUM_W-1:0] wrap_sum;
    logic [N-1:0]     grant_next;

    // A starved requester outranks every priority value; among starved ones
    // the equal keys fall back to round-robin order.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            eligible[i] = (state == IDLE) && req_valid[i]
                          && opens_packet(req_type[i*HEADER_LEN +: HEADER_LEN]);
            closing[i]  = closes_packet(req_type[i*HEADER_LEN +: HEADER_LEN]);
            key[i]      = aged[i] ? {1'b1, {CMP_LEN{1'b0}}}
                                  : {1'b0, req_prio[i*CMP_LEN +: CMP_LEN]};
        end
    end

    // NOTE: every variable gets a default before the loop so no latch is inferred;
    // blocking assignments are correct here because this block is combinational.
    always_comb begin
        found      = 1'b0;
        best_idx   = '0;
        best_key   = '0;
        cand       = '0;
        wrap_sum   = '0;
        grant_next = '0;
        for (int k = 0; k < N; k++) begin
            wrap_sum = {1'b0, rr_ptr} + SUM_W'(k);
            if (wrap_sum >= SUM_W'(N)) begin
                wrap_sum = wrap_sum - SUM_W'(N);
            end
            cand = wrap_sum[IDX_W-1:0];
            // Strict '>' keeps the earliest candidate in rr order on ties.
            if (eligible[cand] && (!found || key[cand] > best_key)) begin
                found    = 1'b1;
                best_idx = cand;
                best_key = key[cand];
            end
        end
        for (int i = 0; i < N; i++) begin
            grant_next[i] = found && (int'(best_idx) == i);
        end
    end

`ifdef ARB_AGING_EN
    localparam int AGE_W = $clog2(AGE_MAX + 1);

    logic [N-1:0] age_inc;
    logic [N-1:0] age_clr;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            age_inc[i] = found && eligible[i] && !grant_next[i];
            age_clr[i] = grant_next[i];
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_age
        arb_age_counter #(
            .AGE_MAX (AGE_MAX),
            .AGE_W   (AGE_W)
        ) u_age (
            .clk       (clk),
            .rst       (rst),
            .inc       (age_inc[i]),
            .clr       (age_clr[i]),
            .saturated (aged[i])
        );
    end
`else
    assign aged = '0;
`endif

    // Reset kills the transfer in the same cycle, before the registers clear.
    assign consume   = rst ? '0 : (grant & req_valid & {N{out_avail}});
    assign out_valid = |consume;
    assign busy      = (state == LOCKED);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            grant     <= '0;
            grant_idx <= '0;
            rr_ptr    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        state     <= LOCKED;
                        grant     <= grant_next;
                        grant_idx <= best_idx;
                    end
                end
                LOCKED: begin
                    if (|(consume & closing)) begin
                        state  <= IDLE;
                        grant  <= '0;
                        rr_ptr <= (int'(grant_idx) == N - 1) ? '0 : grant_idx + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wormhole_output_arbiter.sv
// Directed, table-driven bench for wormhole_output_arbiter (N=3) plus
// hand-written aging and N=1 sequences.
module tb_wormhole_output_arbiter;
    import para::*;

    localparam logic [1:0] H = HEAD_FLIT;
    localparam logic [1:0] B = BODY_FLIT;
    localparam logic [1:0] T = TAIL_FLIT;
    localparam logic [1:0] S = SINGLE_FLIT;

    typedef struct {
        logic        rst;
        logic [2:0]  valid;
        logic [5:0]  typ;
        logic [11:0] prio;
        logic        avail;
        logic [2:0]  grant;
        logic [1:0]  idx;
        logic        busy;
        logic [2:0]  consume;
    } vec_t;

    logic        clk;
    logic        rst;
    logic [2:0]  req_valid;
    logic [5:0]  req_type;
    logic [11:0] req_prio;
    logic        out_avail;
    logic [2:0]  grant;
    logic [1:0]  grant_idx;
    logic [2:0]  consume;
    logic        out_valid;
    logic        busy;

    logic        s_valid;
    logic [1:0]  s_type;
    logic [3:0]  s_prio;
    logic        s_avail;
    logic        s_grant;
    logic        s_idx;
    logic        s_consume;
    logic        s_out_valid;
    logic        s_busy;

    int   n_tests;
    int   n_fail;
    vec_t vecs[$];

    wormhole_output_arbiter #(.N(3), .AGE_MAX(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_type  (req_type),
        .req_prio  (req_prio),
        .out_avail (out_avail),
        .grant     (grant),
        .grant_idx (grant_idx),
        .consume   (consume),
        .out_valid (out_valid),
        .busy      (busy)
    );

    wormhole_output_arbiter #(.N(1), .AGE_MAX(3)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .req_valid (s_valid),
        .req_type  (s_type),
        .req_prio  (s_prio),
        .out_avail (s_avail),
        .grant     (s_grant),
        .grant_idx (s_idx),
        .consume   (s_consume),
        .out_valid (s_out_valid),
        .busy      (s_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic [2:0] v, input logic [5:0] t,
                       input logic [11:0] p, input logic a, input logic [2:0] g,
                       input logic [1:0] gi, input logic b, input logic [2:0] c);
        vec_t e;
        e.rst = r; e.valid = v; e.typ = t; e.prio = p; e.avail = a;
        e.grant = g; e.idx = gi; e.busy = b; e.consume = c;
        vecs.push_back(e);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [2:0] exp_w;
        n_tests   = 0;
        n_fail    = 0;
        rst       = 1'b1;
        req_valid = '0;
        req_type  = '0;
        req_prio  = '0;
        out_avail = 1'b1;
        s_valid   = 1'b0;
        s_type    = H;
        s_prio    = 4'd0;
        s_avail   = 1'b1;

        // Each row: inputs held for one cycle, outputs expected in that cycle.
        add(1, 3'b000, {H,H,H}, {4'd0,4'd0,4'd0}, 1, 3'b000, 0, 0, 3'b000);
        add(1, 3'b000, {H,H,H}, {4'd0,4'd0,4'd0}, 1, 3'b000, 0, 0, 3'b000);
        add(0, 3'b000, {H,H,H}, {4'd0,4'd0,4'd0}, 1, 3'b000, 0, 0, 3'b000);
        add(0, 3'b101, {H,H,H}, {4'd5,4'd0,4'd2}, 1, 3'b000, 0, 0, 3'b000);
        add(0, 3'b101, {H,H,H}, {4'd5,4'd0,4'd2}, 1, 3'b100, 2, 1, 3'b100);
        add(0, 3'b111, {B,H,H}, {4'd5,4'd7,4'd2}, 1, 3'b100, 2, 1, 3'b100);
        add(0, 3'b111, {B,H,H}, {4'd5,4'd7,4'd2}, 1, 3'b100, 2, 1, 3'b100);
        add(0, 3'b111, {T,H,H}, {4'd5,4'd7,4'd2}, 0, 3'b100, 2, 1, 3'b000);
        add(0, 3'b111, {T,H,H}, {4'd5,4'd7,4'd2}, 0, 3'b100, 2, 1, 3'b000);
        add(0, 3'b111, {T,H,H}, {4'd5,4'd7,4'd2}, 0, 3'b100, 2, 1, 3'b000);
        add(0, 3'b011, {T,H,H}, {4'd5,4'd7,4'd2}, 1, 3'b100, 2, 1, 3'b000);
        add(0, 3'b111, {T,H,H}, {4'd5,4'd7,4'd2}, 1, 3'b100, 2, 1, 3'b100);
        add(0, 3'b011, {T,H,H}, {4'd0,4'd7,4'd2}, 1, 3'b000, 0, 0, 3'b000);
        add(0, 3'b011, {T,H,H}, {4'd0,4'd7,4'd2}, 1, 3'b010, 1, 1, 3'b010);
        add(0, 3'b011, {T,T,H}, {4'd0,4'd7,4'd2}, 1, 3'b010, 1, 1, 3'b010);
        add(0, 3'b101, {B,T,H}, {4'd9,4'd0,4'd2}, 1, 3'b000, 0, 0, 3'b000);
        add(0, 3'b101, {B,T,S}, {4'd9,4'd0,4'd2}, 1, 3'b001, 0, 1, 3'b001);
        add(0, 3'b100, {T,H,H}, {4'd9,4'd0,4'd0}, 1, 3'b000, 0, 0, 3'b000);
        add(0, 3'b100, {H,H,H}, {4'd9,4'd0,4'd0}, 1, 3'b000, 0, 0, 3'b000);
        add(0, 3'b100, {H,H,H}, {4'd9,4'd0,4'd0}, 1, 3'b100, 2, 1, 3'b100);
        add(1, 3'b100, {B,H,H}, {4'd9,4'd0,4'd0}, 1, 3'b100, 2, 1, 3'b000);
        add(0, 3'b000, {H,H,H}, {4'd0,4'd0,4'd0}, 1, 3'b000, 0, 0, 3'b000);
        add(0, 3'b011, {H,S,S}, {4'd0,4'd4,4'd4}, 1, 3'b000, 0, 0, 3'b000);
        add(0, 3'b011, {H,S,S}, {4'd0,4'd4,4'd4}, 1, 3'b001, 0, 1, 3'b001);
        add(0, 3'b011, {H,S,S}, {4'd0,4'd4,4'd4}, 1, 3'b000, 0, 0, 3'b000);
        add(0, 3'b011, {H,S,S}, {4'd0,4'd4,4'd4}, 1, 3'b010, 1, 1, 3'b010);
        add(0, 3'b011, {H,S,S}, {4'd0,4'd4,4'd4}, 1, 3'b000, 0, 0, 3'b000);
        add(0, 3'b011, {H,S,S}, {4'd0,4'd4,4'd4}, 1, 3'b001, 0, 1, 3'b001);
        add(0, 3'b011, {H,S,S}, {4'd0,4'd4,4'd4}, 1, 3'b000, 0, 0, 3'b000);
        add(0, 3'b011, {H,S,S}, {4'd0,4'd4,4'd4}, 1, 3'b010, 1, 1, 3'b010);
        add(0, 3'b000, {H,H,H}, {4'd0,4'd0,4'd0}, 1, 3'b000, 0, 0, 3'b000);

        // Unchecked first reset cycle clears the uninitialised registers.
        next_cycle();

        for (int i = 0; i < vecs.size(); i++) begin
            rst       = vecs[i].rst;
            req_valid = vecs[i].valid;
            req_type  = vecs[i].typ;
            req_prio  = vecs[i].prio;
            out_avail = vecs[i].avail;
            @(negedge clk);
            check($sformatf("v%0d grant", i), grant, vecs[i].grant);
            if (vecs[i].grant != 3'b000)
                check($sformatf("v%0d grant_idx", i), grant_idx, vecs[i].idx);
            check($sformatf("v%0d busy", i), busy, vecs[i].busy);
            check($sformatf("v%0d consume", i), consume, vecs[i].consume);
            check($sformatf("v%0d out_valid", i), out_valid, |vecs[i].consume);
            next_cycle();
        end

        // Aging: req0 prio 1 keeps losing to req1 prio 6 in single-flit rounds.
        rst       = 1'b1;
        req_valid = '0;
        next_cycle();
        rst = 1'b0;
        for (int r = 1; r <= 5; r++) begin
            req_valid = 3'b011;
            req_type  = {H, S, S};
            req_prio  = {4'd0, 4'd6, 4'd1};
            out_avail = 1'b1;
`ifdef ARB_AGING_EN
            exp_w = (r == 4) ? 3'b001 : 3'b010;
`else
            exp_w = 3'b010;
`endif
            @(negedge clk);
            check($sformatf("age round%0d idle grant", r), grant, 3'b000);
            next_cycle();
            @(negedge clk);
            check($sformatf("age round%0d winner", r), grant, exp_w);
            check($sformatf("age round%0d consume", r), consume, exp_w);
            next_cycle();
        end
        req_valid = '0;

        // N=1: lock, stall, tail release, idle gap, then single-flit packet.
        s_valid = 1'b1; s_type = H; s_prio = 4'd3; s_avail = 1'b1;
        @(negedge clk);
        check("n1 idle grant", s_grant, 0);
        check("n1 idle busy", s_busy, 0);
        next_cycle();
        s_type = B;
        @(negedge clk);
        check("n1 locked grant", s_grant, 1);
        check("n1 locked idx", s_idx, 0);
        check("n1 body consume", s_consume, 1);
        next_cycle();
        s_type = T; s_avail = 1'b0;
        @(negedge clk);
        check("n1 stall consume", s_consume, 0);
        check("n1 stall grant", s_grant, 1);
        next_cycle();
        s_avail = 1'b1;
        @(negedge clk);
        check("n1 tail consume", s_out_valid, 1);
        next_cycle();
        s_type = S;
        @(negedge clk);
        check("n1 gap grant", s_grant, 0);
        check("n1 gap busy", s_busy, 0);
        next_cycle();
        @(negedge clk);
        check("n1 single grant", s_grant, 1);
        check("n1 single consume", s_consume, 1);
        next_cycle();
        s_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/wormhole_output_arbiter.md
WORMHOLE_OUTPUT_ARBITER -- requirements
Module: wormhole_output_arbiter

Interface
REQ-001 Parameter N, default 3: number of requesters sharing one output port.
REQ-002 Parameter AGE_MAX, default 15: starvation threshold in lost arbitration rounds; AGE_W = $clog2(AGE_MAX+1).
REQ-003 Port clk, input, 1: single clock, all state on rising edge.
REQ-004 Port rst, input, 1: synchronous, active-high reset.
REQ-005 Port req_valid, input, N: bit i set when requester i's front flit is present.
REQ-006 Port req_type, input, HEADER_LEN*N: flit type field of requester i's front flit, slice i.
REQ-007 Port req_prio, input, CMP_LEN*N: priority field of requester i's front flit, slice i.
REQ-008 Port out_avail, input, 1: downstream can accept a flit this cycle.
REQ-009 Port grant, output, N: one-hot current owner, or zero.
REQ-010 Port grant_idx, output, max($clog2(N),1): binary owner index, drives the datapath mux.
REQ-011 Port consume, output, N: consume[i] = grant[i] & req_valid[i] & out_avail.
REQ-012 Port out_valid, output, 1: OR of consume, i.e. a flit transfers this cycle.
REQ-013 Port busy, output, 1: high in state LOCKED.

Function
REQ-014 FSM states: IDLE, LOCKED.
REQ-015 In IDLE, grant = 0, consume = 0, out_valid = 0.
REQ-016 In IDLE, requester i is eligible when req_valid[i] is set and req_type[i] is HEAD_FLIT or SINGLE_FLIT.
REQ-017 BODY_FLIT and TAIL_FLIT fronts are never eligible in IDLE; they are ignored with no state change.
REQ-018 Winner selection: highest req_prio among eligible requesters.
REQ-019 Ties: first eligible index at or after rr_ptr, searched cyclically.
REQ-020 If any eligible requester is present, the winner is registered into grant/grant_idx at the clock edge and the FSM enters LOCKED. Arbitration latency is 1 cycle: the first flit can transfer the cycle after the request.
REQ-021 In LOCKED, grant holds until a consumed flit has type TAIL_FLIT or SINGLE_FLIT. The FSM then returns to IDLE on the next edge, rr_ptr becomes (owner+1) mod N, and grant clears.
REQ-022 In LOCKED, a dropped req_valid or a low out_avail stalls only; grant is retained and no other requester may transfer.
REQ-023 Head/single selection never preempts a locked owner, regardless of priority.
REQ-024 Back-to-back packets: after a tail, at least one IDLE cycle occurs before the next grant.
REQ-025 N=1: the arbitration logic degenerates; the FSM and lock still operate.

Reset
REQ-026 On rst: FSM = IDLE, grant = 0, grant_idx = 0, rr_ptr = 0, all ages = 0, busy = 0.
REQ-027 rst asserted mid-packet aborts the lock immediately; no consume is asserted in the reset cycle.

Configuration
REQ-028 Macro ARB_AGING_EN compiles in starvation aging.
REQ-029 With ARB_AGING_EN, each requester has an AGE_W-bit age counter:
- increments, saturating at AGE_MAX, on each IDLE arbitration in which it is eligible but loses;
- clears when it is granted.
REQ-030 With ARB_AGING_EN, any eligible requester at AGE_MAX overrides priority. Among several such requesters, the REQ-019 round-robin order applies.
REQ-031 Without ARB_AGING_EN, no age state exists and selection follows REQ-018/019 only.

Structure
REQ-032 FLIT_SIZE, HEADER_LEN, CMP_LEN, and the HEAD_FLIT/BODY_FLIT/TAIL_FLIT/SINGLE_FLIT encodings come from the shared package para.sv.
REQ-033 The FSM state enum is also defined in para.sv.
REQ-034 One sub-module, arb_age_counter (a single saturating counter), is instantiated N times under ARB_AGING_EN.

Verification
REQ-035 Reset then idle: rst=1 for 2 cycles, all req_valid=0 -> grant=0, busy=0, out_valid=0 throughout.
REQ-036 Priority: req0 HEAD prio 2, req2 HEAD prio 5 in the same cycle -> grant=3'b100 next cycle, grant_idx=2.
REQ-037 Wormhole lock: req2 sends HEAD,BODY,BODY,TAIL while req1 holds a HEAD with prio 7 -> req1 is not granted until one IDLE cycle after req2's TAIL is consumed.
REQ-038 Stall: out_avail=0 for 3 cycles mid-packet -> consume=0, grant unchanged, busy=1.
REQ-039 Round-robin: req0/req1 both SINGLE with prio 4, repeated -> grants alternate 0,1,0,1.
REQ-040 Aging (ARB_AGING_EN, AGE_MAX=3): req0 prio 1 loses 3 rounds to req1 prio 6 -> req0 granted on the 4th round, and its age clears.
